// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result stream bundle for pipelined_adder.
// With PIPELINED_ADDER_OVF_EN defined it also carries the signed-overflow flag ovf.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: segmented ripple-carry add/sub, one SEG-bit slice per stage, valid/ready stream.
// Define PIPELINED_ADDER_OVF_EN to add a pipelined signed-overflow flag on bus.ovf.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_adder_if.slave bus
);
    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    if (WIDTH % SEG != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of SEG");
    end

    logic             adv;
    logic             v_q   [STAGES];
    logic             c_q   [STAGES];
    logic [WIDTH-1:0] x_q   [STAGES];
    logic [WIDTH-1:0] y_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [SEG:0]     t     [STAGES];
    logic [WIDTH-1:0] s_nxt [STAGES];
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign t[k] = {1'b0, x_q[k][k*SEG +: SEG]} + {1'b0, y_q[k][k*SEG +: SEG]} + (SEG+1)'(c_q[k]);
        // slice k of s_q is still zero here, so OR-ing in the new slice is enough
        assign s_nxt[k] = s_q[k] | (WIDTH'(t[k][SEG-1:0]) << (k * SEG));
        if (k == 0) begin : g_load
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q[0] <= 1'b0;
                    c_q[0] <= 1'b0;
                    x_q[0] <= '0;
                    y_q[0] <= '0;
                    s_q[0] <= '0;
                end else if (adv) begin
                    v_q[0] <= bus.in_valid;
                    c_q[0] <= bus.sub | bus.cin;
                    x_q[0] <= bus.a;
                    y_q[0] <= bus.sub ? ~bus.b : bus.b;
                    s_q[0] <= '0;
                end
            end
        end else begin : g_fwd
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q[k] <= 1'b0;
                    c_q[k] <= 1'b0;
                    x_q[k] <= '0;
                    y_q[k] <= '0;
                    s_q[k] <= '0;
                end else if (adv) begin
                    v_q[k] <= v_q[k-1];
                    c_q[k] <= t[k-1][SEG];
                    x_q[k] <= x_q[k-1];
                    y_q[k] <= y_q[k-1];
                    s_q[k] <= s_nxt[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else if (adv) begin
            out_valid_q <= v_q[LAST];
            sum_q       <= s_nxt[LAST];
            cout_q      <= t[LAST][SEG];
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

`ifdef PIPELINED_ADDER_OVF_EN
    logic ovf_q;

    // carry into the MSB is recovered as a^b^sum at that bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else if (adv) ovf_q <= t[LAST][SEG] ^ x_q[LAST][WIDTH-1] ^ y_q[LAST][WIDTH-1] ^ s_nxt[LAST][WIDTH-1];
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed vectors with scoreboard queue and decoupled output monitor.
module tb_pipelined_adder;
    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t exp_q [$];

    pipelined_adder_if #(.WIDTH(16)) bus ();

    pipelined_adder #(.WIDTH(16), .SEG(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    // called at a negedge; returns at the negedge following the accepting edge
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                        input logic [15:0] esum, input logic ecout, input logic eovf);
        int n;
        exp_t e;
        n = 0;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.sub = sub;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("send_accept", {31'd0, bus.in_ready}, 32'd1);
        e.sum = esum;
        e.cout = ecout;
        e.ovf = eovf;
        if (bus.in_ready) exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out got sum=%h cout=%b want nothing", bus.sum, bus.cout);
                end else begin
                    e = exp_q.pop_front();
`ifdef PIPELINED_ADDER_OVF_EN
                    if (bus.sum !== e.sum || bus.cout !== e.cout || bus.ovf !== e.ovf) begin
                        errors++;
                        $display("FAIL result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                 bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
                    end
`else
                    if (bus.sum !== e.sum || bus.cout !== e.cout) begin
                        errors++;
                        $display("FAIL result got sum=%h cout=%b want sum=%h cout=%b (ovf %b)",
                                 bus.sum, bus.cout, e.sum, e.cout, e.ovf);
                    end
`endif
                end
            end
        end
    end

    initial begin : stim
        int n;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_sum", {16'd0, bus.sum}, 32'd0);
        chk("rst_cout", {31'd0, bus.cout}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // latency: accepted at edge N, visible after edge N+4 for one cycle
        send(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("latency_valid_%0d", i), {31'd0, bus.out_valid}, (i == 4) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // reset with three beats in flight
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
        send(16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0);
        send(16'h4000, 16'h0400, 1'b0, 1'b0, 16'h4400, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_sum", {16'd0, bus.sum}, 32'd0);
        chk("midrst_cout", {31'd0, bus.cout}, 32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("no_stale_valid", {31'd0, bus.out_valid}, 32'd0);
            @(negedge clk);
        end

        // directed add/sub vectors, back-to-back
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send(16'h0100, 16'h0001, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0);
        send(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        send(16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);

        // backpressure: 8-beat stream, stall 5 cycles after the first result
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(16'(i), 16'(i * 3), 1'b0, 1'b0, 16'(i * 4), 1'b0, 1'b0);
                bus.in_valid = 1'b0;
            end
            begin
                n = 0;
                while (!bus.out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_first_valid", {31'd0, bus.out_valid}, 32'd1);
                bus.out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    #1;
                    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
                    chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
                    chk("bp_hold_sum", {16'd0, bus.sum}, 32'd0);
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
        join

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, segmented ripple-carry adder/subtractor. Each pipeline stage adds one SEG-bit slice and registers the carry into the next stage.
- Successor to the fixed 4-bit combinational ripple adder. Adds arbitrary width, add/subtract mode, a valid/ready stream handshake and backpressure.
- Sits in datapaths that need wide adds at high clock rates, with one result per cycle of throughput.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be a multiple of SEG; elaboration fails otherwise.
- SEG, 4, bits added per pipeline stage. STAGES = WIDTH/SEG is the latency in cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry in; ignored when sub=1
- sub  input  1  0: a+b+cin; 1: a-b, i.e. a+~b+1
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB. In sub mode it is the inverted borrow: 1 means a>=b.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, operand/partial-sum/carry registers, sum, cout and out_valid go to 0 immediately. in_ready is combinational and reads 1 during and after reset.
- Reset mid-operation: in-flight beats are discarded and nothing is replayed. The first out_valid after reset comes from a beat accepted after release.
- Pipeline advance: adv = !out_valid || out_ready; in_ready = adv.
  - All stage registers load only when adv=1. Otherwise every stage holds, including sum, cout and out_valid, which stay stable under stall.
  - Input is accepted when in_valid && in_ready.
- Stage 0 captures the following:
  - a;
  - b_eff = sub ? ~b : b;
  - c0 = sub ? 1 : cin;
  - a valid bit equal to in_valid && adv.
- Stage k (0..STAGES-1) computes {c_k+1, s[k*SEG +: SEG]} = a[k*SEG +: SEG] + b_eff[k*SEG +: SEG] + c_k as a SEG+1-bit sum.
  - Already-computed low slices and the not-yet-used high operand slices are forwarded unchanged with the beat.
- Output register holds the final stage: sum = all slices, cout = c_STAGES, out_valid = stage valid.
- Latency: a beat accepted at edge N appears on out_valid/sum at edge N+STAGES, provided no stall occurs.
- Throughput: one beat per cycle while out_ready=1.
- Bubbles (in_valid=0) propagate as invalid stages. They are not compressed.
- Arithmetic is modulo 2^WIDTH. Wrap-around is reported only via cout, e.g. 0xFFFF+0x0001 gives sum=0x0000, cout=1.
- Simultaneous accept and output handoff in the same cycle is legal with no loss.
- SEG=WIDTH is legal and gives a single stage with latency 1.
- While out_valid=1 and out_ready=0, in_ready=0. No beat is dropped or duplicated.

Optional Feature:
- Macro PIPELINED_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit). It flags two's-complement signed overflow, computed as c_STAGES XOR carry into the MSB.
  - ovf is pipelined alongside sum, resets to 0 and holds under stall.
- Undefined: no ovf port and no extra logic. All other behaviour is identical.

Test Plan:
- Reset/idle, WIDTH=16, SEG=4: assert rst_n=0 mid-stream with 3 beats in flight, then release. Expect out_valid=0, sum=0, cout=0 immediately. No stale results appear afterwards.
- Latency: one beat a=0x1234, b=0x0FFF, cin=1, sub=0, out_ready=1. Expect exactly 4 cycles later out_valid=1, sum=0x2234, cout=0; out_valid is 1 for one cycle only.
- Carry ripple across all stages: a=0xFFFF, b=0x0000, cin=1. Expect sum=0x0000, cout=1.
- Subtract:
  - a=0x0005, b=0x0007, sub=1, cin=1 (cin ignored): expect sum=0xFFFE, cout=0.
  - a=0x0100, b=0x0001, sub=1: expect sum=0x00FF, cout=1.
- Backpressure: stream 8 back-to-back beats a=i, b=i*3. Hold out_ready=0 for 5 cycles after the first out_valid.
  - During the stall, expect in_ready=0 and sum stable.
  - Overall, expect results 0,4,8,...,28 in order with none lost or duplicated.
- With PIPELINED_ADDER_OVF_EN defined: a=0x7FFF, b=0x0001 gives ovf=1. a=0x8000, b=0x0001, sub=1 gives ovf=1, sum=0x7FFF. a=0x0001, b=0x0001 gives ovf=0.
